fp_normalize: RTL and testbench
===============================

FP_NORMALIZE -- requirements
Module: fp_normalize

Interface
REQ-001 Parameters SHALL be taken from package fp: EXPONENT_BITS (8), FRACTION_BITS (23), struct float {sign, exp, frac}.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset; asynchronous, active-low.
REQ-004 in_valid  input  1  upstream has a raw sum available.
REQ-005 in_ready  output  1  block can accept a raw sum.
REQ-006 in_sign  input  1  sign of the raw sum.
REQ-007 in_exp  input  EXPONENT_BITS  exponent of the aligned operands, i.e. the larger operand's exponent.
REQ-008 in_mant  input  FRACTION_BITS+2  unsigned magnitude: bit 24 is carry, bit 23 is hidden one, bits 22:0 are fraction.
REQ-009 out_valid  output  1  result holds a normalized value.
REQ-010 out_ready  input  1  downstream accepts the result.
REQ-011 result  output  float  normalized result {sign, exp, frac}.

Function
REQ-012 The FSM SHALL have three states: IDLE, SHIFT and DONE.
REQ-013 in_ready SHALL be 1 only in IDLE; out_valid SHALL be 1 only in DONE.
REQ-014 In IDLE, when in_valid && in_ready, the block SHALL capture sign, exp and mant into working registers and go to SHIFT.
REQ-015 In SHIFT, the block SHALL perform exactly one action per cycle, in this priority order:
  (a) mant==0 -> result {sign, 0, 0}; go to DONE.
  (b) exp==0 -> result {sign, 0, 0} (flush to zero); go to DONE.
  (c) mant[24]==1 -> shift mant right 1 and set exp+1; if exp+1==0xFF then result {sign, 0xFF, 0} (infinity), else result {sign, exp+1, mant[23:1]}; go to DONE.
  (d) mant[23]==1 -> result {sign, exp, mant[22:0]}; go to DONE.
  (e) exp==1 -> result {sign, 0, 0} (underflow flush); go to DONE.
  (f) otherwise -> shift mant left 1, set exp-1, stay in SHIFT.
REQ-016 Shifts SHALL truncate (no rounding), and the bit shifted out on a right shift SHALL be discarded.
REQ-017 Latency SHALL be 2 cycles from the accept edge to out_valid when no left shift is needed, and 2+k cycles for k left shifts (max k=23).
REQ-018 In DONE, result SHALL hold stable while out_ready==0.
REQ-019 When out_valid && out_ready, the block SHALL return to IDLE on the next edge (in_ready=1 in that following cycle); there SHALL be no same-cycle input pass-through.
REQ-020 in_valid, in_exp and in_mant SHALL be ignored outside IDLE.
REQ-021 result SHALL be registered and SHALL change only on entry to DONE.

Reset
REQ-022 While rst_n==0 the block SHALL be in IDLE with in_ready=1, out_valid=0 and result=0, and the working registers SHALL be 0.
REQ-023 Assertion of rst_n during SHIFT or DONE SHALL abort the operation immediately; the pending result is lost and no out_valid is produced.

Verification
REQ-024 sign=0, exp=0x85, mant=0x1800000 -> out_valid 2 cycles after accept; result {0, 0x86, 0x400000}.
REQ-025 sign=0, exp=0x80, mant=0x0800000 -> out_valid 2 cycles after accept; result {0, 0x80, 0x000000}.
REQ-026 sign=0, exp=0x90, mant=0x0000001 -> 23 left shifts; out_valid at cycle 25; result {0, 0x79, 0x000000}.
REQ-027 Special cases:
  - sign=1, exp=0x80, mant=0 -> result {1, 0x00, 0x0}.
  - exp=0xFE, mant=0x1000000 -> result {0, 0xFF, 0x0}.
  - exp=0x02, mant=0x0200000 -> result {0, 0x00, 0x0}.
REQ-028 Backpressure: hold out_ready=0 for 5 cycles in DONE -> result stable and in_ready=0 throughout; then pulse out_ready -> in_ready=1 on the next cycle.
REQ-029 Reset mid-shift: pull rst_n low during case REQ-026 -> out_valid=0 and in_ready=1 immediately; a new input after release -> correct result with no stale data.

Source files
------------

// File: rtl/fp_normalize.sv
// Post-add normalizer for single-precision floats: takes a raw aligned sum
// (carry + hidden one + fraction) and shifts it into normalized form.
package fp;
  localparam int EXPONENT_BITS = 8;
  localparam int FRACTION_BITS = 23;

  typedef struct packed {
    logic                     sign;
    logic [EXPONENT_BITS-1:0] exp;
    logic [FRACTION_BITS-1:0] frac;
  } float;
endpackage

// state | meaning
// IDLE  | waiting for a raw sum, in_ready high
// SHIFT | one normalization step per cycle until the value is settled
// DONE  | result presented with out_valid, held until out_ready
module fp_normalize
  import fp::*;
(
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic                     in_sign,
  input  logic [EXPONENT_BITS-1:0] in_exp,
  input  logic [FRACTION_BITS+1:0] in_mant,
  output logic                     out_valid,
  input  logic                     out_ready,
  output float                     result
);

  localparam int MW = FRACTION_BITS + 2;

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t                   state_q, state_d;
  logic                     sign_q, sign_d;
  logic [EXPONENT_BITS-1:0] exp_q, exp_d;
  logic [MW-1:0]            mant_q, mant_d;
  float                     result_q, result_d;
  logic [EXPONENT_BITS-1:0] exp_inc;

  function automatic float mk_float(input logic                     s,
                                    input logic [EXPONENT_BITS-1:0] e,
                                    input logic [FRACTION_BITS-1:0] f);
    float r;
    r.sign = s;
    r.exp  = e;
    r.frac = f;
    return r;
  endfunction

  assign exp_inc = exp_q + {{(EXPONENT_BITS-1){1'b0}}, 1'b1};

  always_comb begin
    state_d  = state_q;
    sign_d   = sign_q;
    exp_d    = exp_q;
    mant_d   = mant_q;
    result_d = result_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          sign_d  = in_sign;
          exp_d   = in_exp;
          mant_d  = in_mant;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        if (mant_q == '0 || exp_q == '0) begin
          result_d = mk_float(sign_q, '0, '0);
          state_d  = DONE;
        end else if (mant_q[MW-1]) begin
          // Carry out: one right shift, the dropped LSB is simply lost.
          mant_d  = mant_q >> 1;
          exp_d   = exp_inc;
          state_d = DONE;
          if (exp_inc == '1)
            result_d = mk_float(sign_q, '1, '0);
          else
            result_d = mk_float(sign_q, exp_inc, mant_q[FRACTION_BITS:1]);
        end else if (mant_q[MW-2]) begin
          result_d = mk_float(sign_q, exp_q, mant_q[FRACTION_BITS-1:0]);
          state_d  = DONE;
        end else if (exp_q == {{(EXPONENT_BITS-1){1'b0}}, 1'b1}) begin
          result_d = mk_float(sign_q, '0, '0);
          state_d  = DONE;
        end else begin
          mant_d = mant_q << 1;
          exp_d  = exp_q - {{(EXPONENT_BITS-1){1'b0}}, 1'b1};
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      sign_q   <= 1'b0;
      exp_q    <= '0;
      mant_q   <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      sign_q   <= sign_d;
      exp_q    <= exp_d;
      mant_q   <= mant_d;
      result_q <= result_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign result    = result_q;

endmodule

// File: tb/tb_fp_normalize.sv
// Directed bench for fp_normalize: a leading-one based reference model feeds
// an expectation queue that a single compare process checks every cycle.
module tb_fp_normalize;
  import fp::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_sign = 1'b0;
  logic [7:0]  in_exp = '0;
  logic [24:0] in_mant = '0;
  logic        out_ready = 1'b0;
  logic        in_ready;
  logic        out_valid;
  float        result;

  fp_normalize dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_sign   (in_sign),
    .in_exp    (in_exp),
    .in_mant   (in_mant),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    float r;
    int   lat;
    int   acc;
  } exp_t;
  exp_t expq[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic fail(input string name);
    n_tests++;
    n_fail++;
    $display("FAIL %s: got timeout/none, expected event (t=%0t)", name, $time);
  endtask

  // Reference: locate the leading one, then decide between carry, normal,
  // k left shifts, or running out of exponent (flush after exp-1 shifts).
  function automatic void model(input logic s, input logic [7:0] e, input logic [24:0] m,
                                output float r, output int lat);
    int          p;
    int          k;
    logic [7:0]  ne;
    logic [24:0] mm;
    r.sign = s;
    r.exp  = '0;
    r.frac = '0;
    lat    = 2;
    p      = -1;
    if (m == 0 || e == 0) return;
    if (m[24]) begin
      ne = e + 8'd1;
      if (ne == 8'hFF) r.exp = 8'hFF;
      else begin
        r.exp  = ne;
        r.frac = m[23:1];
      end
      return;
    end
    for (int i = 0; i < 24; i++) if (m[i]) p = i;
    k = 23 - p;
    if (int'(e) - k >= 1) begin
      mm     = m << k;
      r.exp  = 8'(int'(e) - k);
      r.frac = mm[22:0];
      lat    = k + 2;
    end else begin
      lat = int'(e) - 1 + 2;
    end
  endfunction

  float  prev_res;
  logic  prev_ov;
  exp_t  cur;

  always @(negedge clk) begin
    if (!rst_n) begin
      prev_ov  = 1'b0;
      prev_res = '0;
    end else begin
      chk("ready_valid_exclusive", 64'(in_ready & out_valid), 64'(0));
      if (out_valid && !prev_ov) begin
        if (expq.size() == 0) fail("unexpected_out_valid");
        else begin
          cur = expq.pop_front();
          chk("result", 64'(result), 64'(cur.r));
          chk("latency", 64'(cyc - cur.acc), 64'(cur.lat));
        end
      end else begin
        chk("result_stable", 64'(result), 64'(prev_res));
        if (out_valid) chk("in_ready_low_in_done", 64'(in_ready), 64'(0));
      end
      prev_ov  = out_valid;
      prev_res = result;
    end
  end

  task automatic send(input logic s, input logic [7:0] e, input logic [24:0] m);
    int   t;
    float r;
    int   lat;
    exp_t x;
    t = 0;
    @(negedge clk);
    while (!in_ready && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (!in_ready) begin
      fail("wait_in_ready");
      return;
    end
    in_valid = 1'b1;
    in_sign  = s;
    in_exp   = e;
    in_mant  = m;
    model(s, e, m, r, lat);
    x.r   = r;
    x.lat = lat;
    x.acc = cyc;
    expq.push_back(x);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_sign  = 1'($urandom);
    in_exp   = 8'($urandom);
    in_mant  = 25'($urandom);
  endtask

  task automatic finish_op(input int hold);
    int t;
    t = 0;
    out_ready = 1'b0;
    @(negedge clk);
    while (!out_valid && t < 60) begin
      @(negedge clk);
      t++;
    end
    if (!out_valid) begin
      fail("wait_out_valid");
      return;
    end
    repeat (hold) @(negedge clk);
    chk("out_valid_held", 64'(out_valid), 64'(1));
    out_ready = 1'b1;
    @(negedge clk);
    chk("in_ready_after_handshake", 64'(in_ready), 64'(1));
    chk("out_valid_after_handshake", 64'(out_valid), 64'(0));
    out_ready = 1'b0;
  endtask

  typedef struct {
    logic        s;
    logic [7:0]  e;
    logic [24:0] m;
    int          hold;
  } vec_t;

  vec_t vecs[$] = '{
    '{1'b0, 8'h85, 25'h1800000, 0},
    '{1'b0, 8'h80, 25'h0800000, 1},
    '{1'b0, 8'h90, 25'h0000001, 0},
    '{1'b1, 8'h80, 25'h0000000, 0},
    '{1'b0, 8'hFE, 25'h1000000, 0},
    '{1'b0, 8'h02, 25'h0200000, 0},
    '{1'b0, 8'h01, 25'h0400000, 0},
    '{1'b1, 8'h00, 25'h0400000, 0},
    '{1'b0, 8'h10, 25'h1FFFFFF, 2},
    '{1'b1, 8'h7F, 25'h0012345, 0},
    '{1'b0, 8'h05, 25'h0000100, 0},
    '{1'b0, 8'h20, 25'h0800000, 5}
  };

  float pr;
  int   pl;

  initial begin
    // Pin the reference model against hand-derived answers.
    model(1'b0, 8'h85, 25'h1800000, pr, pl);
    chk("model_carry", 64'(pr), 64'({1'b0, 8'h86, 23'h400000}));
    chk("model_carry_lat", 64'(pl), 64'(2));
    model(1'b0, 8'h90, 25'h0000001, pr, pl);
    chk("model_23shift", 64'(pr), 64'({1'b0, 8'h79, 23'h0}));
    chk("model_23shift_lat", 64'(pl), 64'(25));
    model(1'b0, 8'hFE, 25'h1000000, pr, pl);
    chk("model_inf", 64'(pr), 64'({1'b0, 8'hFF, 23'h0}));
    model(1'b0, 8'h02, 25'h0200000, pr, pl);
    chk("model_underflow", 64'(pr), 64'({1'b0, 8'h00, 23'h0}));
    chk("model_underflow_lat", 64'(pl), 64'(3));
    model(1'b1, 8'h83, 25'h0030000, pr, pl);
    chk("model_6shift", 64'(pr), 64'({1'b1, 8'h7D, 23'h400000}));

    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_in_ready", 64'(in_ready), 64'(1));
    chk("reset_out_valid", 64'(out_valid), 64'(0));
    chk("reset_result", 64'(result), 64'(0));
    rst_n = 1'b1;

    foreach (vecs[i]) begin
      send(vecs[i].s, vecs[i].e, vecs[i].m);
      finish_op(vecs[i].hold);
    end

    // Abort a long normalization mid-flight.
    send(1'b0, 8'h90, 25'h0000001);
    repeat (10) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("abort_out_valid", 64'(out_valid), 64'(0));
    chk("abort_in_ready", 64'(in_ready), 64'(1));
    chk("abort_result", 64'(result), 64'(0));
    expq.delete();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    send(1'b1, 8'h83, 25'h0030000);
    finish_op(0);
    chk("queue_drained", 64'(expq.size()), 64'(0));

    repeat (3) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
